// File: rtl/duck_pkg.sv
// Shared types and default constants for the light-gun input conditioning path.
package duck_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 250000;
  localparam int unsigned DEF_HIT_THRESHOLD   = 64;
  localparam logic [7:0]  SHOTS_MAX           = 8'd255;

endpackage

// File: rtl/gun_input_cond_if.sv
// Signal bundle between the timing generator / gun hardware and gun_input_cond.
interface gun_input_cond_if;
  import duck_pkg::*;

  // No valid/ready handshake lives here: every signal is a per-cycle level.
  // valid only qualifies sensor samples; screen_reset's rising edge starts a frame.
  logic       trigger_raw;
  logic       sensor_raw;
  logic       valid;
  logic       screen_reset;
  logic       trigger;
  logic       trigger_pulse;
  logic       detect;
  logic [7:0] shots_fired;
  deb_state_e dbg_state;

  modport master (
    output trigger_raw, sensor_raw, valid, screen_reset,
    input  trigger, trigger_pulse, detect, shots_fired, dbg_state
  );

  modport slave (
    input  trigger_raw, sensor_raw, valid, screen_reset,
    output trigger, trigger_pulse, detect, shots_fired, dbg_state
  );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous bit, cleared by synchronous reset.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gun_input_cond.sv
// Light-gun input conditioning: trigger debounce with shot counting, and
// per-frame photodiode hit detection.
module gun_input_cond
  import duck_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HIT_THRESHOLD   = DEF_HIT_THRESHOLD
) (
  input  logic             clk,
  input  logic             rst_n,
  gun_input_cond_if.slave  bus
);

  localparam int unsigned    DW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned    HW       = $clog2(HIT_THRESHOLD) + 1;
  localparam logic [DW-1:0]  DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0]  HIT_MAX  = HW'(HIT_THRESHOLD);

  logic trig_s;
  logic sens_s;

  sync2 u_sync_trig (.clk(clk), .rst_n(rst_n), .d(bus.trigger_raw), .q(trig_s));
  sync2 u_sync_sens (.clk(clk), .rst_n(rst_n), .d(bus.sensor_raw),  .q(sens_s));

  deb_state_e    state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter measures how long the synced trigger has held its new level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RELEASED: begin
        if (trig_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!trig_s)                state_d = RELEASED;
        else if (cnt_q == DEB_LAST) state_d = PRESSED;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      PRESSED: begin
        if (!trig_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (trig_s)                 state_d = PRESSED;
        else if (cnt_q == DEB_LAST) state_d = RELEASED;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = RELEASED;
    endcase
  end

  logic       trigger_q;
  logic       pulse_q;
  logic [7:0] shots_q;

  // PRESSED with trigger still low can only be the first cycle after PRESS_WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trigger_q <= 1'b0;
      pulse_q   <= 1'b0;
      shots_q   <= '0;
    end else begin
      trigger_q <= (state_q == PRESSED) || (state_q == RELEASE_WAIT);
      pulse_q   <= (state_q == PRESSED) && !trigger_q;
      if (pulse_q && (shots_q != SHOTS_MAX)) shots_q <= shots_q + 8'd1;
    end
  end

  logic          sr_q;
  logic          frame_start;
  logic [HW-1:0] hit_q;
  logic          detect_q;

  assign frame_start = bus.screen_reset & ~sr_q;

  // A frame start clears everything and drops that cycle's sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q     <= 1'b0;
      hit_q    <= '0;
      detect_q <= 1'b0;
    end else begin
      sr_q <= bus.screen_reset;
      if (frame_start) begin
        hit_q    <= '0;
        detect_q <= 1'b0;
      end else begin
        detect_q <= (hit_q == HIT_MAX);
        if (bus.valid && sens_s && (hit_q != HIT_MAX)) hit_q <= hit_q + 1'b1;
      end
    end
  end

  assign bus.trigger       = trigger_q;
  assign bus.trigger_pulse = pulse_q;
  assign bus.shots_fired   = shots_q;
  assign bus.detect        = detect_q;
  assign bus.dbg_state     = state_q;

endmodule

// File: doc/gun_input_cond.md
GUN_INPUT_COND -- requirements
Module: gun_input_cond

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, trigger stable-time in clk cycles (10 ms at 25 MHz).
REQ-002 Parameter HIT_THRESHOLD, default 64, bright valid-pixel samples per frame required to declare a hit.
REQ-003 Port clk  input  1  pixel clock; the single clock of the block.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port trigger_raw  input  1  asynchronous gun trigger switch, active-high, bouncy.
REQ-006 Port sensor_raw  input  1  asynchronous photodiode comparator output, high = light seen.
REQ-007 Port valid  input  1  active-video flag from the timing generator.
REQ-008 Port screen_reset  input  1  frame-boundary signal from the timing generator; its rising edge marks frame start.
REQ-009 Port trigger  output  1  debounced trigger level, fed to the game pattern stage.
REQ-010 Port trigger_pulse  output  1  one-cycle pulse on each debounced press.
REQ-011 Port detect  output  1  hit-in-current-frame flag, fed to the game pattern stage.
REQ-012 Port shots_fired  output  8  saturating count of debounced presses.

Function
REQ-013 trigger_raw and sensor_raw each pass through a 2-flop synchronizer; no other logic uses the raw inputs.
REQ-014 Debounce FSM states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-015 RELEASED -> PRESS_WAIT when the synced trigger is 1; the stability counter is cleared.
REQ-016 PRESS_WAIT: the counter increments while the synced trigger is 1; a 0 returns to RELEASED; reaching DEBOUNCE_CYCLES-1 -> PRESSED.
REQ-017 PRESSED -> RELEASE_WAIT when the synced trigger is 0; the counter is cleared.
REQ-018 RELEASE_WAIT: the counter increments while the synced trigger is 0; a 1 returns to PRESSED; reaching DEBOUNCE_CYCLES-1 -> RELEASED.
REQ-019 trigger is 1 in PRESSED and RELEASE_WAIT, otherwise 0, and is registered.
REQ-020 trigger_pulse is 1 for exactly the one cycle after the PRESS_WAIT->PRESSED transition.
REQ-021 shots_fired increments on each trigger_pulse and saturates at 255; it never wraps.
REQ-022 screen_reset is registered once; frame_start = current high AND previous low.
REQ-023 The hit counter, width clog2(HIT_THRESHOLD)+1, increments when valid=1 and the synced sensor=1 in a cycle without frame_start.
REQ-024 The hit counter saturates at HIT_THRESHOLD.
REQ-025 detect rises the cycle after the hit counter first equals HIT_THRESHOLD.
REQ-026 detect stays high through the rest of the frame, including the cycle where screen_reset goes high.
REQ-027 On the cycle after frame_start, detect and the hit counter clear to 0; the frame_start cycle's sample is discarded.
REQ-028 If frame_start and a threshold crossing coincide, the clear wins: detect = 0 and counter = 0.
REQ-029 Samples with valid=0 are ignored regardless of sensor level.
REQ-030 Latency: raw-to-synced is 2 cycles; trigger asserts 2+DEBOUNCE_CYCLES+1 cycles after a clean press edge.

Reset
REQ-031 When rst_n=0 at a clk edge, the following reset: FSM = RELEASED, all counters = 0, synchronizers = 0, screen_reset history = 0.
REQ-032 When rst_n=0 at a clk edge, the outputs reset to trigger=0, trigger_pulse=0, detect=0, shots_fired=0.
REQ-033 Reset asserted mid-debounce or mid-frame abandons all progress; no pulse or detect is emitted on exit.
REQ-034 After reset release, the first frame is counted from the next frame_start; samples before it still accumulate and clear normally.

Structure
REQ-035 The debounce state enum and the default DEBOUNCE_CYCLES and HIT_THRESHOLD constants reside in shared package duck_pkg.
REQ-036 One sub-module, sync2 (2-flop synchronizer, 1 bit), is instantiated twice; everything else stays in gun_input_cond.

Verification
REQ-037 Bounce: toggle trigger_raw 5 times at 100-cycle spacing, then hold it high (DEBOUNCE_CYCLES=1000) -> trigger rises exactly 1003 cycles after the last edge; one trigger_pulse; shots_fired=1.
REQ-038 Short glitch: trigger_raw high for 500 cycles, then low (DEBOUNCE_CYCLES=1000) -> trigger, trigger_pulse and shots_fired all stay 0.
REQ-039 Hit: sensor_raw=1 for 64 valid cycles within one frame (HIT_THRESHOLD=64) -> detect rises on the following cycle, is still 1 at the next screen_reset rise, and is 0 one cycle after frame_start.
REQ-040 Miss: sensor_raw=1 for 63 valid cycles plus 1000 cycles with valid=0 -> detect stays 0, and the counter is 0 after frame_start.
REQ-041 Saturation: 300 debounced presses -> shots_fired=255, and trigger_pulse still fires 300 times.
REQ-042 Reset mid-operation: assert rst_n=0 for 1 cycle during PRESS_WAIT with the hit counter at 40 -> all outputs are 0 and the next frame needs the full 64 samples.
